// File: rtl/microprogram_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : microprogram_sequencer_if
// Description : Control-word / status bundle between the control store and
//               the microprogram sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface microprogram_sequencer_if #(
  parameter int STATE_W = 7
);
  logic [STATE_W-1:0] state_sel;
  logic [2:0]         n;
  logic [STATE_W-1:0] cr;
  logic               cond;
  logic               moc;
  logic [STATE_W-1:0] state;
  logic               illegal_op;
  logic               mem_error;
  logic [7:0]         wait_cnt;

  modport master (
    output state_sel, n, cr, cond, moc,
    input  state, illegal_op, mem_error, wait_cnt
  );

  modport slave (
    input  state_sel, n, cr, cond, moc,
    output state, illegal_op, mem_error, wait_cnt
  );
endinterface
`default_nettype wire

// File: rtl/microprogram_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : microprogram_sequencer
// Description : Microstate register with dispatch/jump/inc/conditional/wait
//               next-state selection and a bounded memory-wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module microprogram_sequencer #(
  parameter int                 STATE_W    = 7,
  parameter int                 TIMEOUT    = 16,
  parameter logic [STATE_W-1:0] TRAP_STATE = 7'd127
) (
  input  wire                         clk,
  input  wire                         rst_n,
  microprogram_sequencer_if.slave     bus
);

  localparam logic [2:0] c_N_DISPATCH  = 3'b000;
  localparam logic [2:0] c_N_FETCH     = 3'b001;
  localparam logic [2:0] c_N_JUMP      = 3'b010;
  localparam logic [2:0] c_N_INC       = 3'b011;
  localparam logic [2:0] c_N_CONDJUMP  = 3'b100;
  localparam logic [2:0] c_N_CONDJUMPN = 3'b101;
  localparam logic [2:0] c_N_WAITINC   = 3'b110;
  localparam logic [2:0] c_N_WAITJUMP  = 3'b111;

  localparam logic [STATE_W-1:0] c_ONE      = STATE_W'(1);
  localparam logic [7:0]         c_TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [7:0]         c_CNT_MAX  = 8'hFF;

  logic [STATE_W-1:0] r_state;
  logic [7:0]         r_wait_cnt;
  logic               r_illegal_op;
  logic               r_mem_error;

  logic [STATE_W-1:0] w_inc;
  logic [STATE_W-1:0] w_next_state;
  logic [7:0]         w_next_wait_cnt;
  logic               w_hold;
  logic               w_timeout;
  logic               w_illegal;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= '0;
      r_wait_cnt   <= '0;
      r_illegal_op <= 1'b0;
      r_mem_error  <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_wait_cnt   <= w_next_wait_cnt;
      r_illegal_op <= w_illegal;
      r_mem_error  <= r_mem_error | w_timeout;
    end
  end

  // Next-state selection
  always_comb begin
    w_inc     = r_state + c_ONE;
    w_hold    = ((bus.n == c_N_WAITINC) || (bus.n == c_N_WAITJUMP)) && !bus.moc;
    // MOC already excludes a hold, so a completing access never times out
    w_timeout = w_hold && (r_wait_cnt == c_TO_LAST);
    w_illegal = (bus.n == c_N_DISPATCH) && (bus.state_sel == '0);

    w_next_state = r_state;
    unique case (bus.n)
      c_N_DISPATCH:  w_next_state = bus.state_sel;
      c_N_FETCH:     w_next_state = '0;
      c_N_JUMP:      w_next_state = bus.cr;
      c_N_INC:       w_next_state = w_inc;
      c_N_CONDJUMP:  w_next_state = bus.cond ? bus.cr : w_inc;
      c_N_CONDJUMPN: w_next_state = bus.cond ? w_inc : bus.cr;
      c_N_WAITINC:   w_next_state = bus.moc ? w_inc : r_state;
      c_N_WAITJUMP:  w_next_state = bus.moc ? bus.cr : r_state;
      default:       w_next_state = r_state;
    endcase
    if (w_timeout) begin
      w_next_state = TRAP_STATE;
    end

    if (!w_hold || w_timeout) begin
      w_next_wait_cnt = '0;
    end else if (r_wait_cnt != c_CNT_MAX) begin
      w_next_wait_cnt = r_wait_cnt + 8'd1;
    end else begin
      w_next_wait_cnt = r_wait_cnt;
    end
  end

  // Outputs
  assign bus.state      = r_state;
  assign bus.wait_cnt   = r_wait_cnt;
  assign bus.illegal_op = r_illegal_op;
  assign bus.mem_error  = r_mem_error;

endmodule
`default_nettype wire

// File: doc/microprogram_sequencer.md
# microprogram_sequencer

Next-state sequencer for the microprogrammed control unit. It holds the current microstate register that addresses the control ROM. Each cycle it selects the next microstate from one of five sources: the instruction encoder's 7-bit dispatch code, a literal jump target from the control word, the incremented state, a conditional choice between those two, or a memory-complete wait/hold. It also enforces a bounded memory-wait timeout that diverts to a trap microstate, and flags unrecognised opcodes at dispatch.

## Interface
- STATE_W, 7, microstate width; matches encoder output width.
- TIMEOUT, 16, maximum consecutive hold cycles in a MOC wait before trapping; legal range 2..255.
- TRAP_STATE, 7'd127, microstate entered on memory-wait timeout.
- Clk  in  1  rising-edge clock.
- Reset_n  in  1  asynchronous, active-low reset.
- State_Sel  in  STATE_W  dispatch code from the instruction encoder; 0 means unrecognised opcode.
- N  in  3  next-state control field from the current control word.
- Cr  in  STATE_W  literal jump target from the current control word.
- Cond  in  1  condition-tester result (branch taken), valid in the same cycle.
- MOC  in  1  memory operation complete, level-sensitive.
- State  out  STATE_W  current microstate (control ROM address).
- Illegal_Op  out  1  one-cycle pulse: a dispatch occurred with State_Sel == 0.
- Mem_Error  out  1  sticky: a memory wait timed out; cleared only by reset.
- Wait_Cnt  out  8  consecutive hold cycles in the current wait; for debug and verification.

## Operation
- Next-state selection uses N. Inc means (State + 1) mod 2^STATE_W, so 127 wraps to 0.
  - 000 Dispatch: next = State_Sel.
  - 001 Fetch: next = 0.
  - 010 Jump: next = Cr.
  - 011 Inc: next = Inc.
  - 100 CondJump: next = Cond ? Cr : Inc.
  - 101 CondJumpN: next = Cond ? Inc : Cr.
  - 110 WaitInc: next = MOC ? Inc : State.
  - 111 WaitJump: next = MOC ? Cr : State.
- Wait counter behaviour:
  - Wait_Cnt increments on every hold cycle, i.e. N is 110 or 111 and MOC = 0.
  - Wait_Cnt clears to 0 on any non-hold cycle.
  - Wait_Cnt saturates at 255.
- Timeout:
  - Condition: hold cycle with Wait_Cnt == TIMEOUT-1.
  - Action: next = TRAP_STATE (overrides the hold), Mem_Error is set, and Wait_Cnt clears.
  - Effect: exactly TIMEOUT hold cycles occur before the trap; the trap is taken on the TIMEOUT-th hold edge.
- MOC wins over timeout: if MOC = 1 in the cycle that would otherwise time out, the normal MOC path is taken and no error is raised.
- Illegal_Op:
  - Registered.
  - Set to 1 for the cycle after any Dispatch with State_Sel == 0; otherwise 0.
  - The dispatch itself still goes to state 0 (refetch).
- Mem_Error stays 1 once set. A second timeout has no further effect on it.
- TRAP_STATE is an ordinary state once entered. Its control word determines what happens next.

## Timing
- Reset (Reset_n low, asynchronous, independent of Clk): State = 0, Wait_Cnt = 0, Illegal_Op = 0, Mem_Error = 0.
- First rising edge after release: State takes next-state from the inputs presented during that cycle.
- Latency: State updates on the rising edge following the presentation of N, Cr, Cond, MOC and State_Sel. All of these are sampled combinationally in that cycle.
- There is no input registering. Selection logic is purely combinational from the current State's control word to the register D input.
- Reset asserted mid-wait: counter and error are cleared immediately, and State returns to 0 with no trap taken.
- MOC arriving on the first wait cycle: zero hold cycles, Wait_Cnt stays 0.
- N changing away from a wait on the same edge MOC rises: the counter clears, as on any non-hold cycle.

## Test plan
- Reset and dispatch: hold Reset_n = 0 with mid-cycle release → State = 0. Then N = 000 with State_Sel = 7'd13 → State = 13 after one edge, Illegal_Op = 0.
- Illegal opcode: N = 000, State_Sel = 0 → State = 0 and Illegal_Op = 1 for exactly one cycle, then 0.
- Conditional and increment: with State = 20, Cr = 50:
  - N = 100, Cond = 1 → State = 50.
  - N = 101, Cond = 1 → State = 21.
  - N = 011 from State = 127 → State = 0.
- Memory wait success: State = 7, N = 110, MOC low for 5 cycles then high → State holds 7 for 5 edges with Wait_Cnt reaching 5, then State = 8, Wait_Cnt = 0, Mem_Error = 0.
- Timeout: TIMEOUT = 16, N = 111, MOC held low → after 16 hold edges State = 127 and Mem_Error = 1 (sticky). Repeating the test leaves Mem_Error at 1.
- Boundary and reset: MOC rises on exactly the 16th hold cycle → Cr is taken and Mem_Error stays 0. Reset_n pulsed low mid-wait with Wait_Cnt = 9 → all outputs are immediately 0.
